button_event_array: RTL and testbench
=====================================

Name: button_event_array

Overview:
- Parametrised, multi-channel push-button conditioner for the player/key inputs.
- Per channel: N-stage synchroniser, then counter-based debouncer, then edge detector.
- Each channel emits exactly one single-cycle event pulse per debounced press, release or both, selected by mode.
- Sits between raw KEY/GPIO pins and the game-logic FSMs. Also reports debounced levels and simultaneous-event flags for tie handling.

Parameters:
- N, 2, number of independent button channels (≥1).
- SYNC_STAGES, 2, synchroniser flop count per channel (≥2).
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the debounced level before that level flips (≥1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous, active-high.
- btn_in  input  N  raw asynchronous button levels, 1 = pressed.
- mode  input  2  event select: 00 = release, 01 = press, 10 = both, 11 = none; sampled every cycle.
- en  input  1  event enable; 0 suppresses pulses, debouncing continues.
- pulse  output  N  registered single-cycle event per channel.
- level  output  N  debounced level per channel (registered).
- any_pulse  output  1  OR of pulse.
- multi_pulse  output  1  1 when two or more bits of pulse are set in the same cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - all synchroniser flops, level, pulse and counters go to 0.
  - any_pulse and multi_pulse are 0 in the following cycle.
  - reset mid-debounce discards the partial count, with no pulse.
- Synchroniser: btn_in[i] is shifted through SYNC_STAGES flops. sync[i] is the last stage.
- Debounce, per channel, every edge:
  - if sync[i] == level[i]: cnt[i] <= 0.
  - else if cnt[i] == DEBOUNCE_CYCLES-1: level[i] <= sync[i], cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- Glitch rule: any return of sync to level before the count completes clears the count. No flip, no pulse.
- Event, registered at the same edge level[i] flips:
  - rise = flip to 1; fall = flip to 0.
  - pulse[i] <= en & ((mode==01 & rise) | (mode==00 & fall) | (mode==10 & (rise|fall))).
  - pulse[i] <= 0 on all other edges, so it is never high more than one cycle per flip.
- Latency: btn_in first sampled at edge 1 at the new value. level and pulse change at edge SYNC_STAGES+DEBOUNCE_CYCLES, which is edge 6 with defaults.
- Minimum spacing: back-to-back events on one channel are at least DEBOUNCE_CYCLES cycles apart.
- en / mode: both are evaluated at the flip edge only. A flip that occurs while en=0 or mode=11 is lost; it is not deferred.
- Button held through reset: level goes 0 to 1 after the normal latency, so press mode emits one press pulse.
- Channels are fully independent, with no arbitration. Simultaneous flips produce simultaneous pulses.
- any_pulse and multi_pulse are combinational from the pulse registers, so they are glitch-free and cycle-aligned with pulse.
- multi_pulse is 0 when N=1.

Test Plan:
- Defaults, mode=01, en=1: btn_in[0] 0→1 held 10 cycles → level[0]=1 and pulse=01 for exactly one cycle after edge 6; no pulse on the later release.
- mode=00: press held 8 cycles then released → level[0] falls 6 edges after release; one pulse, none at press. mode=10, same stimulus → exactly two pulses.
- Glitch: btn_in[1] high for 3 cycles then low, with DEBOUNCE_CYCLES=4 → level and pulse stay 0. Bounce pattern 1,0,1,1,1,1 → exactly one pulse.
- Simultaneous: btn_in=11 asserted on the same edge, mode=01 → pulse=11, any_pulse=1, multi_pulse=1 for one cycle. Offset by 1 cycle → two separate single pulses, multi_pulse=0.
- Suppression: en=0 at the flip edge → no pulse but level updates. en=1 afterwards → no late pulse. mode=11 → no pulses ever.
- Reset: assert reset at count 2 of 4 → all outputs 0. Holding btn_in=1 through release of reset → single press pulse 6 edges after reset deasserts.

Source files
------------

// File: rtl/button_event_array.sv
// Multi-channel push-button conditioner: synchroniser, counter debouncer and
// edge detector per channel, plus any/multi event flags for tie handling.
module button_event_array #(
  parameter int N               = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  input  logic [1:0]   mode,
  input  logic         en,
  output logic [N-1:0] pulse,
  output logic [N-1:0] level,
  output logic         any_pulse,
  output logic         multi_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   level_q;
    logic                   pulse_q;
    logic                   sync_bit;
    logic                   flip;
    logic                   event_sel;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign flip     = (sync_bit != level_q) && (cnt == CNT_LAST);

    // The new level equals sync_bit on a flip, so sync_bit tells rise from fall.
    always_comb begin
      event_sel = 1'b0;
      case (mode)
        2'b00:   event_sel = ~sync_bit;
        2'b01:   event_sel = sync_bit;
        2'b10:   event_sel = 1'b1;
        default: event_sel = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q  <= '0;
        cnt     <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
        pulse_q <= en & flip & event_sel;
        if (sync_bit == level_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level_q <= sync_bit;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign level[i] = level_q;
    assign pulse[i] = pulse_q;
  end

  assign any_pulse = |pulse;

  always_comb begin
    logic seen;
    seen        = 1'b0;
    multi_pulse = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pulse[i]) begin
        if (seen) multi_pulse = 1'b1;
        seen = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_event_array.sv
// Directed bench for button_event_array: expected pulses are queued with the
// cycle they must appear in and checked every cycle by a monitor.
module tb_button_event_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] mode;
  logic       en;
  logic [1:0] pulse;
  logic [1:0] level;
  logic       any_pulse;
  logic       multi_pulse;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  logic check_on = 1'b0;

  button_event_array dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .mode        (mode),
    .en          (en),
    .pulse       (pulse),
    .level       (level),
    .any_pulse   (any_pulse),
    .multi_pulse (multi_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse must appear exactly in the queued cycle and be 0 in every other one.
  always @(negedge clk) begin
    logic [1:0] exp_p;
    if (check_on) begin
      exp_p = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_p = exp_q[0].val;
        void'(exp_q.pop_front());
      end
      checks++;
      assert (pulse === exp_p) else begin
        errors++;
        $error("FAIL pulse cyc=%0d observed=%b expected=%b", cyc, pulse, exp_p);
      end
      checks++;
      assert (any_pulse === |exp_p) else begin
        errors++;
        $error("FAIL any_pulse cyc=%0d observed=%b expected=%b", cyc, any_pulse, |exp_p);
      end
      checks++;
      assert (multi_pulse === &exp_p) else begin
        errors++;
        $error("FAIL multi_pulse cyc=%0d observed=%b expected=%b", cyc, multi_pulse, &exp_p);
      end
    end
  end

  task automatic hold(input logic [1:0] b, input int n);
    btn_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Input driven now is first sampled at the next edge; flip lands 6 edges on.
  task automatic expect_pulse(input logic [1:0] v);
    exp_q.push_back('{cyc + 6, v});
  endtask

  task automatic check_level(input string tag, input logic [1:0] exp_l);
    checks++;
    assert (level === exp_l) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, level, exp_l);
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 2'b00;
    mode   = 2'b01;
    en     = 1'b1;
    @(posedge clk); #1;
    check_on = 1'b1;
    hold(2'b00, 2);
    reset = 1'b0;
    check_level("reset_level", 2'b00);
    hold(2'b00, 3);

    // Press mode: pulse on press only, level flips at edge 6
    mode = 2'b01;
    expect_pulse(2'b01);
    hold(2'b01, 5);
    check_level("press_pre_edge6", 2'b00);
    hold(2'b01, 1);
    check_level("press_edge6", 2'b01);
    hold(2'b01, 4);
    hold(2'b00, 10);
    check_level("press_released", 2'b00);

    // Release mode
    mode = 2'b00;
    hold(2'b01, 8);
    check_level("rel_mode_pressed", 2'b01);
    expect_pulse(2'b01);
    hold(2'b00, 5);
    check_level("rel_pre_edge6", 2'b01);
    hold(2'b00, 1);
    check_level("rel_edge6", 2'b00);
    hold(2'b00, 6);

    // Both mode
    mode = 2'b10;
    expect_pulse(2'b01);
    hold(2'b01, 8);
    expect_pulse(2'b01);
    hold(2'b00, 10);

    // Glitch shorter than the debounce window, then a bounce that settles
    mode = 2'b01;
    hold(2'b10, 3);
    hold(2'b00, 10);
    check_level("glitch_level", 2'b00);
    hold(2'b10, 1);
    hold(2'b00, 1);
    expect_pulse(2'b10);
    hold(2'b10, 12);
    check_level("bounce_level", 2'b10);
    hold(2'b00, 10);

    // Simultaneous and offset presses
    expect_pulse(2'b11);
    hold(2'b11, 10);
    check_level("simul_level", 2'b11);
    hold(2'b00, 10);
    expect_pulse(2'b01);
    hold(2'b01, 1);
    expect_pulse(2'b10);
    hold(2'b11, 10);
    hold(2'b00, 10);

    // Suppression by en and by mode 11; level still tracks
    en = 1'b0;
    hold(2'b01, 10);
    check_level("en0_level", 2'b01);
    en = 1'b1;
    hold(2'b01, 5);
    hold(2'b00, 10);
    mode = 2'b11;
    hold(2'b11, 10);
    check_level("mode11_level", 2'b11);
    hold(2'b00, 10);
    check_level("mode11_released", 2'b00);

    // Reset at count 2 of 4 with the button held through reset
    mode = 2'b01;
    hold(2'b01, 4);
    reset = 1'b1;
    hold(2'b01, 1);
    check_level("reset_mid_level", 2'b00);
    hold(2'b01, 2);
    reset = 1'b0;
    expect_pulse(2'b01);
    hold(2'b01, 10);
    check_level("after_reset_level", 2'b01);
    hold(2'b00, 10);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
    end
    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
